control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 164 ++++++++++++++++
 tb/tb_control_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Steps through a small table of control words and plays each entry to the
//   datapath for (hold + 1) cycles. The table can only be written while idle.
//   A run can loop back to entry 0 forever, or it can finish with a one-cycle
//   done pulse.
//
// Ports
//   clock, reset   rising-edge clock; reset is synchronous and active-high
//   wr_en/wr_addr/wr_word/wr_hold
//                  table write port; it takes effect only in IDLE
//   last_step      index of the final entry; latched at start
//   loop           1 = wrap to entry 0 after last_step; latched at start
//   start, abort   begin a run (in IDLE) / terminate a run (in RUN)
//   control_word   registered word to the datapath; IDLE_WORD when idle
//   step           registered index of the entry being driven
//   busy           high while running
//   done           one-cycle pulse when a non-looping run completes
module control_sequencer #(
  parameter int                  CW_WIDTH  = 37,
  parameter int                  DEPTH     = 8,
  parameter int                  AW        = $clog2(DEPTH),
  parameter int                  HOLD_W    = 4,
  parameter logic [CW_WIDTH-1:0] IDLE_WORD = {CW_WIDTH{1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CW_WIDTH-1:0] wr_word,
  input  logic [HOLD_W-1:0]   wr_hold,
  input  logic [AW-1:0]       last_step,
  input  logic                loop,
  input  logic                start,
  input  logic                abort,
  output logic [CW_WIDTH-1:0] control_word,
  output logic [AW-1:0]       step,
  output logic                busy,
  output logic                done
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [AW-1:0]     STEP_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]     STEP_ONE  = AW'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);

  state_e                             state_q, state_d;
  logic [DEPTH-1:0][CW_WIDTH-1:0]     tbl_word_q, tbl_word_d;
  logic [DEPTH-1:0][HOLD_W-1:0]       tbl_hold_q, tbl_hold_d;
  logic [HOLD_W-1:0]                  hold_cnt_q, hold_cnt_d;
  logic [AW-1:0]                      last_q, last_d;
  logic                               loop_q, loop_d;
  logic [CW_WIDTH-1:0]                control_word_q, control_word_d;
  logic [AW-1:0]                      step_q, step_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;

  // Table write port, open only while idle.
  always_comb begin
    tbl_word_d = tbl_word_q;
    tbl_hold_d = tbl_hold_q;
    if ((state_q == ST_IDLE) && wr_en) begin
      tbl_word_d[wr_addr] = wr_word;
      tbl_hold_d[wr_addr] = wr_hold;
    end else begin
      tbl_word_d = tbl_word_q;
      tbl_hold_d = tbl_hold_q;
    end
  end

  // Sequencer next state. Entries are read from the post-write table view,
  // so a write to entry 0 in the start cycle feeds step 0 directly.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    last_d         = last_q;
    loop_d         = loop_q;
    control_word_d = control_word_q;
    step_d         = step_q;
    done_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_RUN;
          step_d         = STEP_ZERO;
          control_word_d = tbl_word_d[STEP_ZERO];
          hold_cnt_d     = tbl_hold_d[STEP_ZERO];
          last_d         = last_step;
          loop_d         = loop;
        end else begin
          control_word_d = IDLE_WORD;
          step_d         = STEP_ZERO;
          hold_cnt_d     = HOLD_ZERO;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d        = ST_IDLE;
          control_word_d = IDLE_WORD;
          step_d         = STEP_ZERO;
          hold_cnt_d     = HOLD_ZERO;
        end else if (hold_cnt_q != HOLD_ZERO) begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end else if (step_q < last_q) begin
          // Next entry loads on the expiry edge, so there is no gap cycle.
          step_d         = step_q + STEP_ONE;
          control_word_d = tbl_word_d[step_q + STEP_ONE];
          hold_cnt_d     = tbl_hold_d[step_q + STEP_ONE];
        end else if (loop_q) begin
          step_d         = STEP_ZERO;
          control_word_d = tbl_word_d[STEP_ZERO];
          hold_cnt_d     = tbl_hold_d[STEP_ZERO];
        end else begin
          state_d        = ST_IDLE;
          control_word_d = IDLE_WORD;
          step_d         = STEP_ZERO;
          hold_cnt_d     = HOLD_ZERO;
          done_d         = 1'b1;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        control_word_d = IDLE_WORD;
        step_d         = STEP_ZERO;
        hold_cnt_d     = HOLD_ZERO;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset; reset also clears the table.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      tbl_word_q     <= {(DEPTH*CW_WIDTH){1'b0}};
      tbl_hold_q     <= {(DEPTH*HOLD_W){1'b0}};
      hold_cnt_q     <= HOLD_ZERO;
      last_q         <= STEP_ZERO;
      loop_q         <= 1'b0;
      control_word_q <= IDLE_WORD;
      step_q         <= STEP_ZERO;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tbl_word_q     <= tbl_word_d;
      tbl_hold_q     <= tbl_hold_d;
      hold_cnt_q     <= hold_cnt_d;
      last_q         <= last_d;
      loop_q         <= loop_d;
      control_word_q <= control_word_d;
      step_q         <= step_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign control_word = control_word_q;
  assign step         = step_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int CW = 37;
  localparam int AW = 3;
  localparam int HW = 4;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_word = '0;
  logic [HW-1:0] wr_hold = '0;
  logic [AW-1:0] last_step = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] control_word;
  logic [AW-1:0] step;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_word(wr_word), .wr_hold(wr_hold), .last_step(last_step), .loop(loop),
    .start(start), .abort(abort), .control_word(control_word), .step(step),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Reference model: a run is expanded into a queue of per-cycle step indices.
  logic [CW-1:0] m_word [DEPTH];
  logic [HW-1:0] m_hold [DEPTH];
  bit            m_run = 1'b0;
  int            m_last = 0;
  bit            m_loop = 1'b0;
  int            sched[$];
  logic [CW-1:0] e_cw = '0;
  int            e_step = 0;
  bit            e_busy = 1'b0;
  bit            e_done = 1'b0;

  function automatic void build_pass();
    for (int s = 0; s <= m_last; s++)
      for (int k = 0; k <= int'(m_hold[s]); k++)
        sched.push_back(s);
  endfunction

  function automatic void model(input logic r, we, input logic [AW-1:0] wa,
                                input logic [CW-1:0] ww, input logic [HW-1:0] wh,
                                input logic [AW-1:0] ls, input logic lp, st, ab);
    e_done = 1'b0;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin m_word[i] = '0; m_hold[i] = '0; end
      m_run = 1'b0;
      sched.delete();
    end else if (!m_run) begin
      if (we) begin m_word[wa] = ww; m_hold[wa] = wh; end
      if (st) begin
        m_run = 1'b1; m_last = int'(ls); m_loop = lp;
        sched.delete();
        build_pass();
        e_step = sched.pop_front();
      end
    end else if (ab) begin
      m_run = 1'b0;
      sched.delete();
    end else begin
      if (sched.size() == 0) begin
        if (m_loop) build_pass();
        else begin m_run = 1'b0; e_done = 1'b1; end
      end
      if (m_run) e_step = sched.pop_front();
    end
    if (!m_run) e_step = 0;
    e_busy = m_run;
    e_cw   = m_run ? m_word[e_step] : '0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge, compare.
  task automatic tick(input logic r, we, input logic [AW-1:0] wa, input logic [CW-1:0] ww,
                      input logic [HW-1:0] wh, input logic [AW-1:0] ls,
                      input logic lp, st, ab);
    reset = r; wr_en = we; wr_addr = wa; wr_word = ww; wr_hold = wh;
    last_step = ls; loop = lp; start = st; abort = ab;
    model(r, we, wa, ww, wh, ls, lp, st, ab);
    @(posedge clock);
    #1;
    chk("model_cw", 64'(control_word), 64'(e_cw));
    chk("model_step", 64'(step), 64'(e_step));
    chk("model_busy", 64'(busy), 64'(e_busy));
    chk("model_done", 64'(done), 64'(e_done));
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 3'd0, 37'h0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic we; logic [AW-1:0] wa; logic [CW-1:0] ww; logic [HW-1:0] wh;
    logic [AW-1:0] ls; logic lp; logic st; logic ab;
    logic [CW-1:0] cw; logic [AW-1:0] stp; logic bsy; logic dn;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  initial begin
    //          we   wa    ww               wh    ls    lp    st    ab  |  cw               stp   bsy   dn
    vecs[0]  = '{1'b1, 3'd0, 37'h1,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h0,          3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd1, 37'h8020,       4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 37'h0,          3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'd2, 37'h1F00000000, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h0,          3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd2, 1'b0, 1'b1, 1'b0, 37'h1,          3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h1F00000000, 3'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h0,          3'd0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h0,          3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd2, 1'b1, 1'b1, 1'b0, 37'h1,          3'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h1F00000000, 3'd2, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h1,          3'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 37'h0,          3'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 3'd0, 37'h15,         4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 37'h15,         3'd0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 3'd1, 37'hABC,        4'd3, 3'd0, 1'b0, 1'b0, 1'b0, 37'h0,          3'd0, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd1, 1'b0, 1'b1, 1'b0, 37'h15,         3'd0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h0,          3'd0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd2, 1'b1, 1'b1, 1'b0, 37'h15,         3'd0, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h8020,       3'd1, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 37'h1F00000000, 3'd2, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 37'h0,          3'd0, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 3'd0, 37'h0,          4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 37'h0,          3'd0, 1'b0, 1'b0};

    // Reset state.
    tick(1'b1, 1'b0, 3'd0, 37'h0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 3'd3, 37'h7, 4'd2, 3'd1, 1'b1, 1'b1, 1'b0);
    chk("reset_cw", 64'(control_word), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      tick(1'b0, vecs[i].we, vecs[i].wa, vecs[i].ww, vecs[i].wh,
           vecs[i].ls, vecs[i].lp, vecs[i].st, vecs[i].ab);
      chk($sformatf("vec%0d_cw", i), 64'(control_word), 64'(vecs[i].cw));
      chk($sformatf("vec%0d_step", i), 64'(step), 64'(vecs[i].stp));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
      chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].dn));
    end

    // Maximum hold on a one-entry sequence: 16 cycles of the word, done on the 17th.
    tick(1'b0, 1'b1, 3'd0, 37'h2A, 4'd15, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 37'h0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("hold15_first", 64'(control_word), 64'h2A);
    for (int i = 1; i < 16; i++) begin
      idle_tick();
      chk($sformatf("hold15_c%0d", i), 64'({busy, done, control_word}), 64'({1'b1, 1'b0, 37'h2A}));
    end
    idle_tick();
    chk("hold15_done", 64'({busy, done, control_word}), 64'({1'b0, 1'b1, 37'h0}));

    // Reset in the middle of a looping run clears outputs and the table.
    tick(1'b0, 1'b1, 3'd0, 37'h2A, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 37'h0, 4'd0, 3'd2, 1'b1, 1'b1, 1'b0);
    idle_tick();
    idle_tick();
    idle_tick();
    chk("rst_at_step2", 64'(step), 64'd2);
    tick(1'b1, 1'b0, 3'd0, 37'h0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_outs", 64'({busy, done, step, control_word}), 64'h0);
    idle_tick();
    chk("rst_release_idle", 64'({busy, done}), 64'h0);
    tick(1'b0, 1'b0, 3'd0, 37'h0, 4'd0, 3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("zero_tbl_s%0d", i), 64'({busy, step, control_word}), 64'({1'b1, 3'(i), 37'h0}));
      idle_tick();
    end
    chk("zero_tbl_done", 64'({busy, done}), 64'({1'b0, 1'b1}));

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [63:0] w;
      logic [HW-1:0] h;
      w = {32'($urandom), 32'($urandom)};
      h = ($urandom_range(7) == 0) ? 4'd15 : 4'($urandom_range(2));
      tick(($urandom_range(63) == 0), ($urandom_range(3) == 0), 3'($urandom), w[CW-1:0], h,
           3'($urandom), 1'($urandom_range(1)), ($urandom_range(7) == 0),
           ($urandom_range(15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
